mem_bist_ctrl: RTL and testbench



---
 rtl/mem_bist_pkg.sv | 16 +
 rtl/mem_bist_pattern_gen.sv | 27 ++
 rtl/mem_bist_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_bist_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST controller.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_A = 3'd1,
    RD_A = 3'd2,
    WR_B = 3'd3,
    RD_B = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic PASS_A = 1'b0;
  localparam logic PASS_B = 1'b1;

endpackage

// File: rtl/mem_bist_pattern_gen.sv
// Address-derived test pattern: PATTERN ^ addr in pass A, its inverse in pass B.
module mem_bist_pattern_gen
  import mem_bist_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(8'hA5)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  pass_sel,
  output logic [WIDTH-1:0]      data
);

  logic [WIDTH-1:0] addr_ext;

  // Zero-extend or truncate the address to the data width.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ext
    if (i < ADDR_WIDTH) begin : g_bit
      assign addr_ext[i] = addr[i];
    end else begin : g_zero
      assign addr_ext[i] = 1'b0;
    end
  end

  assign data = (pass_sel == PASS_B) ? ~(PATTERN ^ addr_ext) : (PATTERN ^ addr_ext);

endmodule

// File: rtl/mem_bist_ctrl.sv
// Two-pass write/read BIST master for a single-port valid/ready memory.
// Optional MEM_BIST_STOP_ON_FAIL_EN: finish the test at the first read mismatch.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(8'hA5)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  output logic                  valid,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready,
  output state_t                fsm_state
);

  // Handshake: a request is presented while valid=1 and completes at a rising
  // edge with valid=1 and ready=1; addr/wdata/wr_rd hold while ready=0, and the
  // next request is presented at the completing edge.

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_next;
  logic                  pass_sel;
  logic [WIDTH-1:0]      pattern;
  logic                  fire;
  logic                  last;
  logic                  mismatch;
  logic                  stop_hit;
  logic [ADDR_WIDTH+1:0] err_next;

  mem_bist_pattern_gen #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PATTERN    (PATTERN)
  ) u_pattern_gen (
    .addr     (addr),
    .pass_sel (pass_sel),
    .data     (pattern)
  );

  assign fire      = valid && ready;
  assign last      = (addr == LAST_ADDR);
  assign mismatch  = fire && !wr_rd && (rdata != pattern);
  assign err_next  = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;
  assign fsm_state = state;

`ifdef MEM_BIST_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    valid      = 1'b0;
    wr_rd      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    pass_sel   = PASS_A;
    case (state)
      IDLE: begin
        if (start) state_next = WR_A;
      end
      WR_A: begin
        valid = 1'b1;
        wr_rd = 1'b1;
        busy  = 1'b1;
        if (fire && last) state_next = RD_A;
      end
      RD_A: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (stop_hit) state_next = DONE;
        else if (fire && last) state_next = WR_B;
      end
      WR_B: begin
        valid    = 1'b1;
        wr_rd    = 1'b1;
        busy     = 1'b1;
        pass_sel = PASS_B;
        if (fire && last) state_next = RD_B;
      end
      RD_B: begin
        valid    = 1'b1;
        busy     = 1'b1;
        pass_sel = PASS_B;
        if (stop_hit || (fire && last)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    wdata = wr_rd ? pattern : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      err_count <= '0;
      fail_addr <= '0;
      pass      <= 1'b0;
    end else begin
      state     <= state_next;
      err_count <= err_next;
      if (fire) addr <= (last || stop_hit) ? '0 : addr + 1'b1;
      if (mismatch && (err_count == '0)) fail_addr <= addr;
      // The verdict is latched on entry to DONE so it is visible with done.
      if ((state_next == DONE) && (state != DONE)) pass <= (err_next == '0);
      if ((state == IDLE) && start) begin
        addr      <= '0;
        err_count <= '0;
        fail_addr <= '0;
        pass      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Self-checking bench for mem_bist_ctrl with a behavioural memory and fault injection.
module tb_mem_bist_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_addr;
  logic [5:0] err_count;
  logic       wr_rd;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       valid;
  logic [7:0] rdata;
  logic       ready;
  mem_bist_pkg::state_t fsm_state;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int ready_mode = 0;
  bit sb_en = 1'b0;
  bit stall_prev = 1'b0;
  logic [12:0] stall_val;
  logic [12:0] exp_q[$];

  logic [7:0] mem [16];
  bit         fault_en = 1'b0;
  logic [3:0] fault_addr = 4'd0;
  logic [7:0] fault_mask = 8'h00;

  mem_bist_ctrl #(
    .WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4), .PATTERN(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .err_count(err_count), .wr_rd(wr_rd), .addr(addr),
    .wdata(wdata), .valid(valid), .rdata(rdata), .ready(ready), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt++;

  // Memory model with an optional read-side stuck-bit fault
  always @(posedge clk) if (valid && ready && wr_rd) mem[addr] <= wdata;
  assign rdata = mem[addr] ^ ((fault_en && (addr == fault_addr)) ? fault_mask : 8'h00);

  always @(negedge clk) begin
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      default: ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Scoreboard: every completed transfer against the expected sequence, plus stall hold
  always @(negedge clk) begin
    #1;
    if (sb_en && !rst) begin
      if (stall_prev) begin
        checks++;
        if ({valid, wr_rd, addr, wdata} !== {1'b1, stall_val}) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b req=%h, required valid=1 req=%h",
                   valid, {wr_rd, addr, wdata}, stall_val);
        end
      end
      stall_prev = valid && !ready;
      stall_val  = {wr_rd, addr, wdata};
      if (valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_extra: got req=%h, required none", {wr_rd, addr, wdata});
        end else begin
          logic [12:0] exp_x;
          exp_x = exp_q.pop_front();
          if ({wr_rd, addr, wdata} !== exp_x) begin
            errors++;
            $display("FAIL xfer: got req=%h, required %h", {wr_rd, addr, wdata}, exp_x);
          end
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Reference: full request sequence derived from the pattern rules
  task automatic fill_exp();
    exp_q.delete();
    for (int p = 0; p < 2; p++) begin
      for (int rw = 1; rw >= 0; rw--) begin
        for (int a = 0; a < 16; a++) begin
          logic [7:0] pat;
          logic [3:0] a4;
          a4  = 4'(a);
          pat = 8'hA5 ^ {4'h0, a4};
          if (p == 1) pat = ~pat;
          exp_q.push_back({rw[0], a4, (rw == 1) ? pat : 8'h00});
        end
      end
    end
  endtask

  // Reference: outcome of a test for a given read fault
  function automatic void model(input bit f_en, input logic [3:0] f_addr, input logic [7:0] f_mask,
                                output int n_err, output int first, output int n_x);
    n_err = 0;
    first = 0;
    n_x   = 0;
    for (int p = 0; p < 2; p++) begin
      n_x += 16;
      for (int a = 0; a < 16; a++) begin
        n_x++;
        if (f_en && (a == int'(f_addr)) && (f_mask != 8'h00)) begin
          if (n_err == 0) first = a;
          n_err++;
`ifdef MEM_BIST_STOP_ON_FAIL_EN
          return;
`endif
        end
      end
    end
  endfunction

  // Driver: accept start, then wait (bounded) for done; -1 on timeout
  task automatic run_test(input int start_again_at, output int done_edges);
    int e0;
    done_edges = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = edge_cnt;
    for (int c = 0; c < 400; c++) begin
      start = (c == start_again_at);
      if (done) begin
        done_edges = edge_cnt - e0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, valid, wr_rd, addr, wdata, fail_addr, err_count} !== 27'd0 ||
        fsm_state !== mem_bist_pkg::IDLE) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b pass=%0b valid=%0b wr_rd=%0b addr=%0d wdata=%h fa=%0d ec=%0d st=%0d, required all 0 / IDLE",
               busy, done, pass, valid, wr_rd, addr, wdata, fail_addr, err_count, fsm_state);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_run();
    int de, n_err, first, n_x;
    ready_mode = 0;
    fault_en = 1'b0;
    model(1'b0, 4'd0, 8'h00, n_err, first, n_x);
    fill_exp();
    sb_en = 1'b1;
    run_test(-1, de);
    checks++;
    if (de !== n_x) begin
      errors++;
      $display("FAIL clean_latency: got %0d edges, required %0d", de, n_x);
    end
    checks++;
    if ({pass, err_count, fail_addr, busy, valid} !== {1'b1, 6'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clean_result: got pass=%0b ec=%0d fa=%0d busy=%0b valid=%0b, required 1/0/0/0/0",
               pass, err_count, fail_addr, busy, valid);
    end
    @(negedge clk);
    checks++;
    if ({done, pass} !== 2'b01) begin
      errors++;
      $display("FAIL done_pulse_hold: got done=%0b pass=%0b, required done=0 pass=1", done, pass);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL clean_xfer_count: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_stuck_bit();
    int de, n_err, first, n_x;
    ready_mode = 0;
    fault_en   = 1'b1;
    fault_addr = 4'd3;
    fault_mask = 8'h01;
    model(1'b1, 4'd3, 8'h01, n_err, first, n_x);
    fill_exp();
    run_test(-1, de);
    checks++;
    if (de !== n_x) begin
      errors++;
      $display("FAIL stuck_latency: got %0d edges, required %0d", de, n_x);
    end
    checks++;
    if ({pass, err_count, fail_addr} !== {1'b0, 6'(n_err), 4'(first)}) begin
      errors++;
      $display("FAIL stuck_result: got pass=%0b ec=%0d fa=%0d, required 0/%0d/%0d",
               pass, err_count, fail_addr, n_err, first);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 64 - n_x) begin
      errors++;
      $display("FAIL stuck_xfer_count: got %0d left, required %0d", exp_q.size(), 64 - n_x);
    end
    fault_en = 1'b0;
  endtask

  task automatic test_ready_toggle();
    int de;
    ready_mode = 1;
    fault_en = 1'b0;
    fill_exp();
    run_test(-1, de);
    checks++;
    if (de < 127 || de > 128) begin
      errors++;
      $display("FAIL toggle_latency: got %0d edges, required 127..128", de);
    end
    checks++;
    if ({pass, err_count} !== {1'b1, 6'd0} || exp_q.size() != 0) begin
      errors++;
      $display("FAIL toggle_result: got pass=%0b ec=%0d left=%0d, required 1/0/0",
               pass, err_count, exp_q.size());
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_mid();
    int e0, n_done, de;
    ready_mode = 0;
    fault_en = 1'b0;
    fill_exp();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = edge_cnt;
    for (int c = 0; c < 50 && (edge_cnt - e0) < 11; c++) @(negedge clk);
    sb_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid, busy, done, pass, err_count} !== 10'd0 || fsm_state !== mem_bist_pkg::IDLE) begin
      errors++;
      $display("FAIL reset_mid: got valid=%0b busy=%0b done=%0b pass=%0b ec=%0d st=%0d, required 0/0/0/0/0/IDLE",
               valid, busy, done, pass, err_count, fsm_state);
    end
    rst = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done pulses, required 0", n_done);
    end
    fill_exp();
    sb_en = 1'b1;
    run_test(-1, de);
    checks++;
    if (de !== 64 || pass !== 1'b1) begin
      errors++;
      $display("FAIL reset_rerun: got %0d edges pass=%0b, required 64 / 1", de, pass);
    end
  endtask

  task automatic test_start_while_busy();
    int de;
    ready_mode = 0;
    fault_en = 1'b0;
    fill_exp();
    run_test(30, de);
    checks++;
    if (de !== 64 || pass !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: got %0d edges pass=%0b, required 64 / 1", de, pass);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fsm_state !== mem_bist_pkg::IDLE || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_start_idle: got busy=%0b st=%0d left=%0d, required 0/IDLE/0",
               busy, fsm_state, exp_q.size());
    end
  endtask

  task automatic test_random();
    int de, n_err, first, n_x;
    for (int it = 0; it < 6; it++) begin
      ready_mode = 2;
      fault_en   = ($urandom_range(0, 3) != 0);
      fault_addr = 4'($urandom_range(0, 15));
      fault_mask = 8'($urandom_range(1, 255));
      model(fault_en, fault_addr, fault_mask, n_err, first, n_x);
      fill_exp();
      run_test(-1, de);
      checks++;
      if (de < n_x) begin
        errors++;
        $display("FAIL rand_latency[%0d]: got %0d edges, required >= %0d", it, de, n_x);
      end
      checks++;
      if ({pass, err_count, fail_addr} !== {(n_err == 0), 6'(n_err), 4'(first)}) begin
        errors++;
        $display("FAIL rand_result[%0d]: got pass=%0b ec=%0d fa=%0d, required %0b/%0d/%0d",
                 it, pass, err_count, fail_addr, (n_err == 0), n_err, first);
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 64 - n_x) begin
        errors++;
        $display("FAIL rand_xfer_count[%0d]: got %0d left, required %0d", it, exp_q.size(), 64 - n_x);
      end
    end
    fault_en = 1'b0;
    ready_mode = 0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    test_reset();
    test_clean_run();
    test_stuck_bit();
    test_ready_toggle();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
